// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the multi-cycle ALU:
//   - op_e    : 4-bit operation codes driven on aluop
//   - state_e : control FSM encoding (IDLE / ITER / DONE)
//   - op_is_single / op_is_iter : decode helpers used by the top level
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_MUL  = 4'b1001,
    OP_DIVU = 4'b1010,
    OP_REMU = 4'b1011
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ops finished in the accepting cycle: the contiguous range AND..SRA.
  function automatic logic op_is_single(input logic [3:0] op);
    return (op <= OP_SRA);
  endfunction

  // Ops handled by the iterative multiply/divide datapath.
  function automatic logic op_is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
//   Request/response bundle of the multi-cycle ALU.
//   Request : in_valid, in_ready, a, b, aluop
//   Response: out_valid, out_ready, result, flag, ovf, illegal
//   master  : the requester (drives operands, consumes the result)
//   slave   : the ALU
// -----------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       aluop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, a, b, aluop, out_ready,
    input  in_ready, out_valid, result, flag, ovf, illegal
  );

  modport slave (
    input  in_valid, a, b, aluop, out_ready,
    output in_ready, out_valid, result, flag, ovf, illegal
  );
endinterface

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
//   Iterative datapath: shift-add multiply (one partial product per cycle) and
//   restoring unsigned division (one quotient bit per cycle). Runs exactly
//   WIDTH steps after start_i; done_o flags the final step, during which
//   result_o already shows the value that step produces.
//   Ports:
//     clk, reset : clock, async active-high reset
//     start_i    : load operands and begin (one-cycle pulse)
//     op_i       : OP_MUL / OP_DIVU / OP_REMU
//     a_i, b_i   : operands
//     done_o     : final step in progress this cycle
//     result_o   : product low bits, quotient or remainder
// -----------------------------------------------------------------------------
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic             is_mul_q;
  logic             is_rem_q;
  // MUL : acc = partial product, x = multiplier (shifts right), y = multiplicand (shifts left)
  // DIV : acc = partial remainder, x = dividend shifting out / quotient shifting in, y = divisor
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [WIDTH-1:0] acc_d, x_d, y_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;

  assign rem_shift = {acc_q, x_q[WIDTH-1]};
  assign rem_sub   = rem_shift - {1'b0, y_q};

  // A zero divisor never makes rem_sub negative, so the quotient fills with
  // ones and the remainder collects all of a: no special case is needed.
  always_comb begin
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    if (is_mul_q) begin
      acc_d = x_q[0] ? (acc_q + y_q) : acc_q;
      x_d   = x_q >> 1;
      y_d   = y_q << 1;
    end else if (!rem_sub[WIDTH]) begin
      acc_d = rem_sub[WIDTH-1:0];
      x_d   = {x_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rem_shift[WIDTH-1:0];
      x_d   = {x_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done_o   = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign result_o = (is_mul_q || is_rem_q) ? acc_d : x_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (done_o) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // NOTE: datapath registers carry no reset; only busy/counter must be known
  // after reset, and operands are always loaded by start_i before use.
  always_ff @(posedge clk) begin
    if (start_i) begin
      is_mul_q <= (op_i == OP_MUL);
      is_rem_q <= (op_i == OP_REMU);
      acc_q    <= '0;
      x_q      <= (op_i == OP_MUL) ? b_i : a_i;
      y_q      <= (op_i == OP_MUL) ? a_i : b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
//   Multi-cycle ALU with valid/ready handshakes on request and response.
//   Logic/shift/add/sub/slt ops complete one cycle after acceptance; MUL, DIVU
//   and REMU take WIDTH+1 cycles through alu_iter. Results are registered and
//   held in DONE until the consumer takes them.
//   Parameters: WIDTH (power of two, >= 8), MULDIV_EN (0 makes MUL/DIVU/REMU illegal)
//   Ports:
//     clk   : clock
//     reset : async active-high reset, aborts any operation in flight
//     bus   : alu_mc_if.slave request/response bundle
// -----------------------------------------------------------------------------
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.flag      = flag_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = illegal_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign shamt  = bus.b[SHW-1:0];
  assign sum    = bus.a + bus.b;
  assign diff   = bus.a - bus.b;

  // Single-cycle results straight from the request operands; illegal and
  // iterative codes fall to the zero default.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.aluop)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SLL: alu_res = bus.a << shamt;
      OP_SRL: alu_res = bus.a >> shamt;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SRA: alu_res = $signed(bus.a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flag_d     = flag_q;
    ovf_d      = ovf_q;
    illegal_d  = illegal_q;
    iter_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (MULDIV_EN && op_is_iter(bus.aluop)) begin
            iter_start = 1'b1;
            state_d    = S_ITER;
          end else begin
            state_d   = S_DONE;
            illegal_d = !op_is_single(bus.aluop);
            result_d  = alu_res;
            ovf_d     = alu_ovf;
            flag_d    = (alu_res == '0);
          end
        end
      end
      S_ITER: begin
        if (iter_done) begin
          state_d   = S_DONE;
          result_d  = iter_result;
          flag_d    = (iter_result == '0);
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: clocked blocks use non-blocking (<=) so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      flag_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flag_q    <= flag_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  if (MULDIV_EN) begin : g_iter
    alu_iter #(
      .WIDTH (WIDTH)
    ) u_iter (
      .clk      (clk),
      .reset    (reset),
      .start_i  (iter_start),
      .op_i     (bus.aluop),
      .a_i      (bus.a),
      .b_i      (bus.b),
      .done_o   (iter_done),
      .result_o (iter_result)
    );
  end else begin : g_no_iter
    assign iter_done   = 1'b0;
    assign iter_result = '0;
  end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
//   Self-checking bench for alu_mc at WIDTH=32: directed vector table,
//   hand-written handshake/reset sequences, and random ops compared against
//   an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(
    .WIDTH     (W),
    .MULDIV_EN (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         fl;
    logic         ov;
    logic         il;
    int           lat;
    bit           busy_ok;
    bit           stable_ok;
    bit           ready_after;
  } obs_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         fl;
    logic         ov;
    logic         il;
    int           lat;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] r, input logic fl,
                         input logic ov, input logic il, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.r = r; v.fl = fl; v.ov = ov; v.il = il; v.lat = lat;
    vq.push_back(v);
  endtask

  // Reference model: plain wide arithmetic on the operation's definition.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ov, output logic il,
                                output int lat);
    longint sa, sb, wide, lmax, lmin;
    logic [63:0] ua, ub;
    int sh;
    sa   = $signed(a);
    sb   = $signed(b);
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    sh   = int'(b % W);
    lmax = (longint'(1) << (W - 1)) - 1;
    lmin = -(longint'(1) << (W - 1));
    r    = '0;
    ov   = 1'b0;
    il   = 1'b0;
    lat  = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: begin wide = sa + sb; r = W'(wide); ov = (wide > lmax) || (wide < lmin); end
      4'h3: r = a ^ b;
      4'h4: r = a << sh;
      4'h5: r = a >> sh;
      4'h6: begin wide = sa - sb; r = W'(wide); ov = (wide > lmax) || (wide < lmin); end
      4'h7: r = (sa < sb) ? W'(1) : W'(0);
      4'h8: r = W'(sa >>> sh);
      4'h9: begin r = W'(ua * ub); lat = W + 1; end
      4'hA: begin r = (b == 0) ? '1 : a / b; lat = W + 1; end
      4'hB: begin r = (b == 0) ? a : a % b; lat = W + 1; end
      default: il = 1'b1;
    endcase
  endfunction

  // Issue one request, scramble the inputs after acceptance (optionally with
  // in_valid held high), measure latency, hold off out_ready for 'stall'
  // cycles, then complete the handshake.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit noise, output obs_t o);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.aluop    = op;
    @(posedge clk);
    #1;
    bus.in_valid = noise;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.aluop    = 4'($urandom_range(0, 15));
    o.lat        = 1;
    o.busy_ok    = 1'b1;
    while (!bus.out_valid && o.lat < 100) begin
      if (bus.in_ready) o.busy_ok = 1'b0;
      @(posedge clk);
      #1;
      o.lat++;
    end
    if (bus.in_ready) o.busy_ok = 1'b0;
    bus.in_valid = 1'b0;
    o.r  = bus.result;
    o.fl = bus.flag;
    o.ov = bus.ovf;
    o.il = bus.illegal;
    o.stable_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      if (bus.result !== o.r || bus.flag !== o.fl || bus.ovf !== o.ov ||
          bus.illegal !== o.il || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        o.stable_ok = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    o.ready_after = bus.in_ready && !bus.out_valid;
  endtask

  task automatic expect_obs(input string tag, input obs_t o, input logic [W-1:0] r,
                            input logic fl, input logic ov, input logic il, input int lat);
    check($sformatf("%s result", tag),      o.r, r);
    check($sformatf("%s flag", tag),        W'(o.fl), W'(fl));
    check($sformatf("%s ovf", tag),         W'(o.ov), W'(ov));
    check($sformatf("%s illegal", tag),     W'(o.il), W'(il));
    check($sformatf("%s latency", tag),     W'(o.lat), W'(lat));
    check($sformatf("%s busy", tag),        W'(o.busy_ok), W'(1));
    check($sformatf("%s hold", tag),        W'(o.stable_ok), W'(1));
    check($sformatf("%s ready_after", tag), W'(o.ready_after), W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t         o;
    logic [W-1:0] er;
    logic         eo, ei;
    int           el;
    bit           seen;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    int           mode;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.aluop     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  W'(bus.in_ready),  W'(1));
    check("reset out_valid", W'(bus.out_valid), W'(0));
    check("reset result",    bus.result,        '0);
    check("reset flag",      W'(bus.flag),      W'(0));
    check("reset ovf",       W'(bus.ovf),       W'(0));
    check("reset illegal",   W'(bus.illegal),   W'(0));
    @(negedge clk);
    reset = 1'b0;

    // name, op, a, b, result, flag, ovf, illegal, latency
    add_vec("add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1, 0, 1);
    add_vec("sub_zero",  4'b0110, 32'd5,         32'd5,         32'h0,         1, 0, 0, 1);
    add_vec("sub_ovf",   4'b0110, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 1, 0, 1);
    add_vec("add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0, 0, 1);
    add_vec("and",       4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0, 1);
    add_vec("or",        4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0, 0, 0, 1);
    add_vec("xor_self",  4'b0011, 32'h1234_5678, 32'h1234_5678, 32'h0,         1, 0, 0, 1);
    add_vec("sll_31",    4'b0100, 32'h1,         32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 1);
    add_vec("srl_31",    4'b0101, 32'h8000_0000, 32'h1F,        32'h1,         0, 0, 0, 1);
    add_vec("slt_neg",   4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0, 1);
    add_vec("sra_4",     4'b1000, 32'h8000_0000, 32'h24,        32'hF800_0000, 0, 0, 0, 1);
    add_vec("mul",       4'b1001, 32'h2000,      32'h17FB,      32'h02FF_6000, 0, 0, 0, 33);
    add_vec("mul_max",   4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         0, 0, 0, 33);
    add_vec("divu",      4'b1010, 32'd100,       32'd7,         32'd14,        0, 0, 0, 33);
    add_vec("remu",      4'b1011, 32'd100,       32'd7,         32'd2,         0, 0, 0, 33);
    add_vec("divu_by0",  4'b1010, 32'd100,       32'd0,         32'hFFFF_FFFF, 0, 0, 0, 33);
    add_vec("remu_by0",  4'b1011, 32'd100,       32'd0,         32'd100,       0, 0, 0, 33);
    add_vec("ill_1111",  4'b1111, 32'h55,        32'hAA,        32'h0,         1, 0, 1, 1);
    add_vec("ill_1100",  4'b1100, 32'h55,        32'hAA,        32'h0,         1, 0, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i].op, vq[i].a, vq[i].b, 0, 1'b0, o);
      expect_obs(vq[i].name, o, vq[i].r, vq[i].fl, vq[i].ov, vq[i].il, vq[i].lat);
    end

    // Backpressure: result held for 5 cycles, in_ready returns after handshake.
    run_op(4'b0010, 32'd3, 32'd4, 5, 1'b0, o);
    expect_obs("backpressure", o, 32'd7, 0, 0, 0, 1);

    // in_valid held high during ITER/DONE must be ignored, not queued.
    run_op(4'b1001, 32'd123, 32'd456, 2, 1'b1, o);
    expect_obs("ignore_valid", o, 32'd56088, 0, 0, 0, 33);
    @(posedge clk);
    #1;
    check("ignore_valid no queued op", W'(bus.out_valid), W'(0));

    // Reset 10 cycles into a DIVU aborts it with no result delivered.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.aluop    = 4'b1010;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort in_ready",  W'(bus.in_ready),  W'(1));
    check("abort out_valid", W'(bus.out_valid), W'(0));
    check("abort result",    bus.result,        '0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort no result",      W'(seen),         W'(0));
    check("abort in_ready after", W'(bus.in_ready), W'(1));
    run_op(4'b1111, 32'h1, 32'h2, 0, 1'b0, o);
    expect_obs("after_abort_ill", o, 32'h0, 1, 0, 1, 1);
    run_op(4'b1010, 32'd100, 32'd7, 0, 1'b0, o);
    expect_obs("after_abort_divu", o, 32'd14, 0, 0, 0, 33);

    // Random ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop  = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 3);
      ra   = $urandom;
      rb   = (mode == 0) ? '0 : (mode == 1) ? W'($urandom_range(1, 255)) : W'($urandom);
      model(rop, ra, rb, er, eo, ei, el);
      run_op(rop, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)), o);
      expect_obs($sformatf("rand%0d op%0h", n, rop), o, er, (er == '0), eo, ei, el);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; the block SHALL support any WIDTH >= 8 that is a power of two.
REQ-002 Parameter MULDIV_EN, default 1, enables the MUL/DIVU/REMU ops; at 0 those ops SHALL be illegal.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; low log2(WIDTH) bits give the shift amount.
REQ-009 aluop  input  4  operation select.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 flag  output  1  zero flag, 1 when result == 0.
REQ-014 ovf  output  1  signed overflow for ADD/SUB, 0 for all other ops.
REQ-015 illegal  output  1  the op was unsupported or disabled.

Function
REQ-016 Op encoding SHALL be:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
- 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed, result 1/0)
- 1000 SRA, 1001 MUL (low WIDTH bits), 1010 DIVU, 1011 REMU
- all other codes illegal.
REQ-017 The FSM SHALL have states IDLE, ITER and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready.
REQ-019 Single-cycle ops (0000-1000): on acceptance the block SHALL go IDLE->DONE, with out_valid=1 on the next cycle (latency 1).
REQ-020 MUL/DIVU/REMU: on acceptance the block SHALL go IDLE->ITER, run exactly WIDTH iteration cycles, then go to DONE; out_valid SHALL rise WIDTH+1 cycles after acceptance.
REQ-021 MUL SHALL be shift-add, one partial product per cycle; DIVU/REMU SHALL be restoring division, one quotient bit per cycle.
REQ-022 Divide by zero: DIVU SHALL return all ones and REMU SHALL return a, each with full latency; illegal SHALL stay 0.
REQ-023 Illegal op: the block SHALL go to DONE with latency 1, result=0, flag=1, illegal=1.
REQ-024 In DONE, result, flag, ovf and illegal SHALL hold stable until out_valid && out_ready; the block then returns to IDLE on that edge.
REQ-025 Operands and aluop SHALL be captured at acceptance; input changes after that SHALL have no effect.
REQ-026 in_valid during ITER or DONE SHALL be ignored (not queued).
REQ-027 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf SHALL be set when the operand signs and result sign indicate signed overflow.

Reset
REQ-028 Reset SHALL force state=IDLE, in_ready=1, out_valid=0, result=0, flag=0, ovf=0, illegal=0, and clear the iteration counter.
REQ-029 Reset asserted mid-ITER or mid-DONE SHALL abort the operation with no result delivered.

Structure
REQ-030 Package alu_pkg SHALL hold the op-code constants and the FSM state encoding.
REQ-031 The iterative multiply/divide datapath SHALL be the sub-module alu_iter, omitted by generate when MULDIV_EN=0.

Verification (WIDTH=32)
REQ-032 ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1, flag=0, out_valid 1 cycle after acceptance.
REQ-033 SUB a=5, b=5 -> result=0, flag=1, ovf=0.
REQ-034 MUL a=0x2000, b=0x17FB -> result=0x02FF6000, out_valid exactly 33 cycles after acceptance, in_ready=0 throughout.
REQ-035 DIVU a=100, b=7 -> 14; REMU -> 2; DIVU with b=0 -> 0xFFFFFFFF; REMU with b=0 -> 100.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> result held stable and in_ready=0; out_ready=1 -> in_ready=1 next cycle.
REQ-037 Reset pulse 10 cycles into a DIVU, and aluop=1111 -> out_valid=0 and in_ready=1 after reset; aluop=1111 gives result=0 with illegal=1.
